// File: rtl/pipe_pkg.sv
// Shared pipeline payload definitions: stage kill-field layouts, widths and bubble values.
package pipe_pkg;

    // Same encoding as RV32I_Inst_Pkg::INST_NOP (addi x0, x0, 0)
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int XLEN          = 32;
    localparam int PC_W          = 32;
    localparam int IF_ID_KILL_W  = 32;
    localparam int ID_EX_KILL_W  = 97;
    localparam int EX_MEM_KILL_W = 98;
    localparam int MEM_WB_KILL_W = 65;

    typedef struct packed {
        logic [31:0] instr;
    } if_id_kill_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic            reg_we;
    } id_ex_kill_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic            mem_we;
        logic            reg_we;
    } ex_mem_kill_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] wb_data;
        logic            reg_we;
    } mem_wb_kill_t;

    localparam if_id_kill_t IF_ID_BUBBLE = '{instr: INST_NOP};

    localparam id_ex_kill_t ID_EX_BUBBLE = '{
        instr: INST_NOP, rs1_val: '0, rs2_val: '0, reg_we: 1'b0};

    localparam ex_mem_kill_t EX_MEM_BUBBLE = '{
        instr: INST_NOP, alu_result: '0, store_data: '0, mem_we: 1'b0, reg_we: 1'b0};

    localparam mem_wb_kill_t MEM_WB_BUBBLE = '{
        instr: INST_NOP, wb_data: '0, reg_we: 1'b0};

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// One pipeline entry register (valid + sticky + kill) with load, clear-to-bubble and hold.
module pipe_slot #(
    parameter int                STICKY_W    = 32,
    parameter int                KILL_W      = 97,
    parameter logic [KILL_W-1:0] BUBBLE_KILL = '0
) (
    input  logic                clk,
    input  logic                rst_sync,
    input  logic                load,
    input  logic                clear,
    input  logic                sticky_load,
    input  logic [STICKY_W-1:0] d_sticky,
    input  logic [KILL_W-1:0]   d_kill,
    output logic                q_valid,
    output logic [STICKY_W-1:0] q_sticky,
    output logic [KILL_W-1:0]   q_kill
);

    // Clear wins over load; a clear may still capture a new sticky value.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            q_valid  <= 1'b0;
            q_sticky <= '0;
            q_kill   <= BUBBLE_KILL;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_kill  <= BUBBLE_KILL;
            if (sticky_load)
                q_sticky <= d_sticky;
        end else if (load) begin
            q_valid  <= 1'b1;
            q_sticky <= d_sticky;
            q_kill   <= d_kill;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and squash counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                STICKY_W    = 32,
    parameter int                KILL_W      = 97,
    parameter logic [KILL_W-1:0] BUBBLE_KILL = KILL_W'(ID_EX_BUBBLE),
    parameter int                CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_sync,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [STICKY_W-1:0] in_sticky,
    input  logic [KILL_W-1:0]   in_kill,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [STICKY_W-1:0] out_sticky,
    output logic [KILL_W-1:0]   out_kill,
    output logic [CNT_W-1:0]    squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                m_valid, s_valid;
    logic [STICKY_W-1:0] m_sticky, s_sticky;
    logic [KILL_W-1:0]   m_kill, s_kill;
    logic                accept, advance;
    logic                m_load, m_clear, m_sticky_load, s_load, s_clear;
    logic [STICKY_W-1:0] m_d_sticky;
    logic [KILL_W-1:0]   m_d_kill;
    logic [1:0]          squash_inc;
    logic [CNT_W+1:0]    squash_sum;

    // in_ready only looks at S, so out_ready never reaches it combinationally
    assign in_ready = !s_valid && !rst_sync;
    assign accept   = in_valid && in_ready;
    assign advance  = out_ready || !m_valid;

    // Accept implies S is empty, so a flush-time sticky load always takes in_sticky
    assign m_load        = advance && (s_valid || accept);
    assign m_clear       = flush || (advance && !s_valid && !accept);
    assign m_sticky_load = flush && accept;
    assign m_d_sticky    = s_valid ? s_sticky : in_sticky;
    assign m_d_kill      = s_valid ? s_kill   : in_kill;

    assign s_load  = accept && !advance;
    assign s_clear = flush || (advance && s_valid);

    pipe_slot #(.STICKY_W(STICKY_W), .KILL_W(KILL_W), .BUBBLE_KILL(BUBBLE_KILL)) u_m_slot (
        .clk         (clk),
        .rst_sync    (rst_sync),
        .load        (m_load),
        .clear       (m_clear),
        .sticky_load (m_sticky_load),
        .d_sticky    (m_d_sticky),
        .d_kill      (m_d_kill),
        .q_valid     (m_valid),
        .q_sticky    (m_sticky),
        .q_kill      (m_kill)
    );

    pipe_slot #(.STICKY_W(STICKY_W), .KILL_W(KILL_W), .BUBBLE_KILL(BUBBLE_KILL)) u_s_slot (
        .clk         (clk),
        .rst_sync    (rst_sync),
        .load        (s_load),
        .clear       (s_clear),
        .sticky_load (1'b0),
        .d_sticky    (in_sticky),
        .d_kill      (in_kill),
        .q_valid     (s_valid),
        .q_sticky    (s_sticky),
        .q_kill      (s_kill)
    );

    // Two guard bits keep the sum exact even when CNT_W is tiny
    assign squash_inc = {1'b0, m_valid} + {1'b0, s_valid} + {1'b0, accept};
    assign squash_sum = {2'b00, squash_cnt} + {{CNT_W{1'b0}}, squash_inc};

    always_ff @(posedge clk) begin
        if (rst_sync)
            squash_cnt <= '0;
        else if (flush) begin
            if (squash_sum > {2'b00, CNT_MAX})
                squash_cnt <= CNT_MAX;
            else
                squash_cnt <= squash_sum[CNT_W-1:0];
        end
    end

    assign out_valid  = m_valid;
    assign out_sticky = m_sticky;
    assign out_kill   = m_kill;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized and directed bench for pipe_skid_stage against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam logic [96:0] EXP_BUBBLE = {32'h0000_0013, 64'b0, 1'b0};

    typedef struct packed {
        logic [31:0] s;
        logic [96:0] k;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_sync, flush, in_valid, out_ready;
    logic [31:0] in_sticky;
    logic [96:0] in_kill;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_sticky_a;
    logic [96:0] out_kill_a;
    logic [15:0] squash_cnt_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] out_sticky_b;
    logic [96:0] out_kill_b;
    logic [1:0]  squash_cnt_b;

    ent_t        q[$];
    logic [31:0] hold_sticky;
    int          cnt_a, cnt_b;
    int          n_compared, n_mismatched;
    bit          last_acc;
    bit          have_item, random_mode;
    logic [31:0] item_s;
    logic [96:0] item_k;
    int          next_kill;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk(clk), .rst_sync(rst_sync), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_sticky(in_sticky), .in_kill(in_kill),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sticky(out_sticky_a), .out_kill(out_kill_a),
        .squash_cnt(squash_cnt_a)
    );

    pipe_skid_stage #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_sync(rst_sync), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_sticky(in_sticky), .in_kill(in_kill),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sticky(out_sticky_b), .out_kill(out_kill_b),
        .squash_cnt(squash_cnt_b)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int satAdd(input int a, input int n, input int max);
        return (a + n > max) ? max : a + n;
    endfunction

    // Drive one cycle, check the pre-edge outputs, then advance the model across the edge.
    task automatic applyStimulus(input bit r, input bit f, input bit iv, input bit ordy,
                                 input logic [31:0] st, input logic [96:0] kl);
        bit          ev, eir, acc;
        logic [31:0] es, cur_s;
        logic [96:0] ek;
        int          n;
        rst_sync = r; flush = f; in_valid = iv; out_ready = ordy;
        in_sticky = st; in_kill = kl;
        #1;
        ev  = (q.size() > 0);
        ek  = ev ? q[0].k : EXP_BUBBLE;
        es  = ev ? q[0].s : hold_sticky;
        eir = !r && (q.size() < 2);
        checkOutput("out_valid",    128'(out_valid_a),  128'(ev));
        checkOutput("out_kill",     128'(out_kill_a),   128'(ek));
        checkOutput("out_sticky",   128'(out_sticky_a), 128'(es));
        checkOutput("in_ready",     128'(in_ready_a),   128'(eir));
        checkOutput("squash_cnt",   128'(squash_cnt_a), 128'(cnt_a));
        checkOutput("out_valid_b",  128'(out_valid_b),  128'(ev));
        checkOutput("squash_cnt_b", 128'(squash_cnt_b), 128'(cnt_b));
        checkOutput("s_implies_m",  128'(!(dut.s_valid && !dut.m_valid)), 128'(1));
        acc   = iv && eir;
        cur_s = es;
        @(posedge clk);
        if (r) begin
            q.delete();
            hold_sticky = '0;
            cnt_a = 0;
            cnt_b = 0;
        end else if (f) begin
            n = q.size() + (acc ? 1 : 0);
            cnt_a = satAdd(cnt_a, n, 65535);
            cnt_b = satAdd(cnt_b, n, 3);
            hold_sticky = acc ? st : cur_s;
            q.delete();
        end else begin
            if (ordy && q.size() > 0)
                void'(q.pop_front());
            if (acc)
                q.push_back('{s: st, k: kl});
            if (q.size() == 0)
                hold_sticky = cur_s;
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    // Upstream source: keeps offering the same entry until it is accepted.
    task automatic produce(input bit r, input bit f, input bit ordy, input bit want);
        if (want && !have_item) begin
            have_item = 1'b1;
            item_s    = $urandom;
            item_k    = random_mode ? 97'({$urandom, $urandom, $urandom, $urandom}) : 97'(next_kill);
            next_kill++;
        end
        applyStimulus(r, f, have_item, ordy, item_s, item_k);
        if (last_acc)
            have_item = 1'b0;
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0;
        cnt_a = 0; cnt_b = 0; hold_sticky = '0;
        have_item = 1'b0; random_mode = 1'b0; next_kill = 1;
        item_s = '0; item_k = '0; last_acc = 1'b0;
        rst_sync = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sticky = '0; in_kill = '0;
        @(posedge clk);
        @(negedge clk);

        repeat (2) produce(1, 0, 1, 1);

        // Streaming, then input stops to expose the bubble
        for (int i = 0; i < 8; i++) produce(0, 0, 1, 1);
        repeat (2) produce(0, 0, 1, 0);

        // Stall with skid
        produce(0, 0, 1, 1);
        repeat (3) produce(0, 0, 0, 1);
        repeat (4) produce(0, 0, 1, 1);
        repeat (3) produce(0, 0, 1, 0);

        // Flush with both slots full, then with M full plus an accept
        repeat (3) produce(0, 0, 0, 1);
        produce(0, 1, 0, 1);
        produce(0, 0, 0, 1);
        produce(0, 1, 1, 1);
        repeat (2) produce(0, 0, 1, 0);

        // Repeated full flushes drive the narrow counter into saturation
        for (int i = 0; i < 3; i++) begin
            repeat (2) produce(0, 0, 0, 1);
            produce(0, 1, 0, 0);
        end

        // Reset while S is full and input is offered
        repeat (2) produce(0, 0, 0, 1);
        produce(1, 0, 0, 1);
        repeat (3) produce(0, 0, 1, 0);

        random_mode = 1'b1;
        for (int i = 0; i < 600; i++)
            produce($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 4,
                    ($urandom % 4) != 0, ($urandom % 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
